// File: rtl/link_arbiter_pkg.sv
// Shared widths, beat-count helper and FSM state type for the link arbiter slice.
package link_arbiter_pkg;

    localparam int MEM_ADDR_SIZE           = 16;
    localparam int WORD_SIZE_BIT           = 32;
    localparam int BANDWIDTH_WRITE_ADDRESS = 8;

    // Number of link beats needed to carry a payload of payload_w bits.
    function automatic int link_beats(input int payload_w, input int beat_w);
        return (payload_w + beat_w - 1) / beat_w;
    endfunction

    localparam int LINK_BEATS = link_beats(MEM_ADDR_SIZE + WORD_SIZE_BIT,
                                           BANDWIDTH_WRITE_ADDRESS);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEND   = 2'd1,
        COMMIT = 2'd2
    } link_state_t;

endpackage

// File: rtl/link_arbiter_serializer.sv
// Link serializer: loads a zero-padded payload, emits one registered beat per
// cycle LSB-first, and flags the final beat. Beat output returns to zero
// whenever it is neither loading nor advancing.
module link_serializer #(
    parameter int PW    = 48,
    parameter int BUS_W = 8,
    parameter int BEATS = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             advance,
    input  logic [PW-1:0]    payload,
    output logic [BUS_W-1:0] beat,
    output logic             last_beat
);

    localparam int FW    = BEATS * BUS_W;
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

    logic [FW-1:0]    frame_in;
    logic [FW-1:0]    rest;
    logic [CNT_W-1:0] idx;

    // Upper bits of the final beat are padding and stay zero.
    assign frame_in  = FW'(payload);
    assign last_beat = (idx == CNT_W'(BEATS - 1));

    // Beat register, remaining-beat shifter and beat index.
    always_ff @(posedge clk) begin
        if (reset) begin
            beat <= '0;
            rest <= '0;
            idx  <= '0;
        end else if (load) begin
            beat <= frame_in[BUS_W-1:0];
            rest <= frame_in >> BUS_W;
            idx  <= '0;
        end else if (advance) begin
            beat <= rest[BUS_W-1:0];
            rest <= rest >> BUS_W;
            idx  <= idx + 1'b1;
        end else begin
            beat <= '0;
        end
    end

endmodule

// File: rtl/link_arbiter.sv
// Two-requester round-robin arbiter that serializes {addr, data} onto a narrow
// link as a SEND burst followed by a one-cycle COMMIT carrying the ack.
module link_arbiter
    import link_arbiter_pkg::*;
#(
    parameter int ADDR_W = MEM_ADDR_SIZE,
    parameter int DATA_W = WORD_SIZE_BIT,
    parameter int BUS_W  = BANDWIDTH_WRITE_ADDRESS
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] data0,
    input  logic [DATA_W-1:0] data1,
    output logic              ack0,
    output logic              ack1,
    output logic              send,
    output logic              write_in,
    output logic [BUS_W-1:0]  bus,
    output logic              busy
);

    localparam int PW    = ADDR_W + DATA_W;
    localparam int BEATS = link_beats(PW, BUS_W);

    link_state_t    state, next_state;
    logic           gnt, gnt_next;
    logic           last_served;
    logic           start, advance, last_beat;
    logic           send_d, busy_d, ack0_d, ack1_d, write_d;
    logic [PW-1:0]  payload;

    assign payload = gnt_next ? {addr1, data1} : {addr0, data0};

    link_serializer #(
        .PW    (PW),
        .BUS_W (BUS_W),
        .BEATS (BEATS)
    ) u_serializer (
        .clk       (clk),
        .reset     (reset),
        .load      (start),
        .advance   (advance),
        .payload   (payload),
        .beat      (bus),
        .last_beat (last_beat)
    );

    // State, grant, round-robin pointer and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            gnt         <= 1'b0;
            last_served <= 1'b1;
            send        <= 1'b0;
            busy        <= 1'b0;
            ack0        <= 1'b0;
            ack1        <= 1'b0;
            write_in    <= 1'b0;
        end else begin
            state    <= next_state;
            gnt      <= gnt_next;
            if (state == COMMIT) begin
                last_served <= gnt;
            end
            send     <= send_d;
            busy     <= busy_d;
            ack0     <= ack0_d;
            ack1     <= ack1_d;
            write_in <= write_d;
        end
    end

    // Next state, arbitration and serializer control.
    always_comb begin
        next_state = state;
        gnt_next   = gnt;
        start      = 1'b0;
        advance    = 1'b0;
        case (state)
            IDLE: begin
                if (req0 || req1) begin
                    next_state = SEND;
                    start      = 1'b1;
                    gnt_next   = (req0 && req1) ? ~last_served : req1;
                end
            end
            SEND: begin
                if (last_beat) begin
                    next_state = COMMIT;
                end else begin
                    advance = 1'b1;
                end
            end
            COMMIT:  next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Outputs are decoded from next_state so they land in flops in step with state.
    always_comb begin
        send_d  = (next_state == SEND);
        busy_d  = (next_state != IDLE);
        ack0_d  = (next_state == COMMIT) && !gnt;
        ack1_d  = (next_state == COMMIT) && gnt;
        write_d = start ? (gnt_next ? we1 : we0) : write_in;
    end

endmodule

// File: tb/tb_link_arbiter.sv
// Self-checking bench for link_arbiter: queue-based frame model compared every
// cycle, directed literal scenarios, then randomized traffic with resets.
module tb_link_arbiter;

    logic        clk;
    logic        reset;
    logic        req0, req1, we0, we1;
    logic [15:0] addr0, addr1;
    logic [31:0] data0, data1;
    logic        ack0, ack1, send, write_in, busy;
    logic [7:0]  bus;
    logic        ack0_20, ack1_20, send_20, write_in_20, busy_20;
    logic [7:0]  bus_20;

    link_arbiter #(.ADDR_W(16), .DATA_W(32), .BUS_W(8)) u_dut (
        .clk(clk), .reset(reset), .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .data0(data0), .data1(data1),
        .ack0(ack0), .ack1(ack1), .send(send), .write_in(write_in), .bus(bus), .busy(busy)
    );

    link_arbiter #(.ADDR_W(16), .DATA_W(20), .BUS_W(8)) u_dut20 (
        .clk(clk), .reset(reset), .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .data0(data0[19:0]), .data1(data1[19:0]),
        .ack0(ack0_20), .ack1(ack1_20), .send(send_20), .write_in(write_in_20),
        .bus(bus_20), .busy(busy_20)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, expv, $time);
        end
    endtask

    // ---------------- behavioural model (6-beat configuration) ----------------
    typedef struct packed {
        logic       send;
        logic [7:0] bus;
        logic       wr;
        logic       ack0;
        logic       ack1;
        logic       busy;
    } exp_t;

    exp_t mq[$];
    exp_t exp_o;
    logic m_last;
    logic m_wr;
    bit   model_ok = 0;

    // Whole-frame expectation is queued at the grant edge, then replayed per cycle.
    always @(posedge clk) begin
        logic        g;
        logic        w;
        logic [47:0] pay;
        if (reset) begin
            mq.delete();
            m_last = 1'b1;
            m_wr   = 1'b0;
            exp_o  = '{send: 1'b0, bus: 8'h00, wr: 1'b0, ack0: 1'b0, ack1: 1'b0, busy: 1'b0};
        end else begin
            if (mq.size() == 0 && (req0 || req1)) begin
                if (req0 && req1) g = (m_last == 1'b1) ? 1'b0 : 1'b1;
                else              g = req1;
                pay  = g ? {addr1, data1} : {addr0, data0};
                w    = g ? we1 : we0;
                m_wr = w;
                for (int k = 0; k < 6; k++)
                    mq.push_back('{send: 1'b1, bus: pay[8*k +: 8], wr: w,
                                   ack0: 1'b0, ack1: 1'b0, busy: 1'b1});
                mq.push_back('{send: 1'b0, bus: 8'h00, wr: w, ack0: !g, ack1: g, busy: 1'b1});
                mq.push_back('{send: 1'b0, bus: 8'h00, wr: w, ack0: 1'b0, ack1: 1'b0, busy: 1'b0});
            end
            if (mq.size() > 0) begin
                exp_o = mq.pop_front();
                if (exp_o.ack0) m_last = 1'b0;
                if (exp_o.ack1) m_last = 1'b1;
            end else begin
                exp_o = '{send: 1'b0, bus: 8'h00, wr: m_wr, ack0: 1'b0, ack1: 1'b0, busy: 1'b0};
            end
        end
        model_ok = 1;
    end

    // Per-cycle comparison of the 6-beat DUT against the model.
    always @(negedge clk) begin
        if (model_ok) begin
            chk("m_send", send, exp_o.send);
            chk("m_bus", bus, exp_o.bus);
            chk("m_busy", busy, exp_o.busy);
            chk("m_ack0", ack0, exp_o.ack0);
            chk("m_ack1", ack1, exp_o.ack1);
            if (exp_o.send || exp_o.ack0 || exp_o.ack1)
                chk("m_write_in", write_in, exp_o.wr);
        end
    end

    // ---------------- link receiver model ----------------
    logic [47:0] rx_buf  = '0;
    int          rx_n    = 0;
    int          rx_cnt  = 0;
    logic [15:0] rx_addr = '0;
    logic [31:0] rx_data = '0;
    logic        rx_wr   = 1'b0;

    // Reassemble frames from the beat stream; reset discards a partial frame.
    always @(negedge clk) begin
        if (reset) begin
            rx_n   = 0;
            rx_buf = '0;
        end else if (send) begin
            rx_buf = rx_buf | (48'(bus) << (8 * rx_n));
            rx_n++;
            rx_wr  = write_in;
        end else if (rx_n > 0) begin
            rx_addr = rx_buf[47:32];
            rx_data = rx_buf[31:0];
            rx_cnt++;
            rx_n   = 0;
            rx_buf = '0;
        end
    end

    // ---------------- stimulus ----------------
    logic [7:0] beats[$];
    logic [7:0] lit37[6];
    logic [7:0] lit42[5];
    int         ack_id[$];
    int         ack_c[$];
    int         ackc, nb, rxc0;
    bit         seen;

    initial begin
        lit37 = '{8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h34, 8'h12};
        lit42 = '{8'hEF, 8'hBE, 8'hDF, 8'hBC, 8'h0A};
        reset = 1'b1;
        req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
        addr0 = '0; addr1 = '0; data0 = '0; data1 = '0;
        repeat (3) @(negedge clk);

        // Reset state.
        chk("rst_send", send, 1'b0);
        chk("rst_bus", bus, 8'h00);
        chk("rst_busy", busy, 1'b0);
        chk("rst_acks", {ack0, ack1}, 2'b00);
        chk("rst_write_in", write_in, 1'b0);
        chk("rst20_busy", busy_20, 1'b0);
        reset = 1'b0;

        // Write from requester 0; data changes after grant must not reach the link.
        req0 = 1'b1; we0 = 1'b1; addr0 = 16'h1234; data0 = 32'hDEADBEEF;
        beats.delete(); ackc = 0;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (send) beats.push_back(bus);
            if (ack1) chk("t37_no_ack1", ack1, 1'b0);
            if (c == 1) data0 = 32'h0;
            if (ack0) begin ackc = c; break; end
        end
        req0 = 1'b0;
        chk("t37_ack_cycle", ackc, 7);
        chk("t37_nbeats", beats.size(), 6);
        for (int k = 0; k < 6 && k < beats.size(); k++) chk("t37_beat", beats[k], lit37[k]);
        repeat (2) @(negedge clk);
        chk("t37_rx_addr", rx_addr, 16'h1234);
        chk("t37_rx_data", rx_data, 32'hDEADBEEF);
        chk("t37_rx_wr", rx_wr, 1'b1);

        // Read from requester 1.
        req1 = 1'b1; we1 = 1'b0; addr1 = 16'h00FF; data1 = 32'h13572468;
        ackc = 0;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (send || ack1) chk("t39_write_in", write_in, 1'b0);
            if (ack0) chk("t39_no_ack0", ack0, 1'b0);
            if (ack1) begin ackc = c; break; end
        end
        req1 = 1'b0;
        chk("t39_ack_cycle", ackc, 7);
        repeat (2) @(negedge clk);
        chk("t39_rx_addr", rx_addr, 16'h00FF);
        chk("t39_rx_wr", rx_wr, 1'b0);

        // Both requesting continuously from reset: alternate, 8 cycles apart.
        reset = 1'b1; req0 = 1'b1; req1 = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        ack_id.delete(); ack_c.delete();
        for (int c = 1; c <= 40 && ack_id.size() < 4; c++) begin
            @(negedge clk);
            if (ack0) begin ack_id.push_back(0); ack_c.push_back(c); end
            if (ack1) begin ack_id.push_back(1); ack_c.push_back(c); end
        end
        req0 = 1'b0; req1 = 1'b0;
        chk("t38_nacks", ack_id.size(), 4);
        for (int k = 0; k < 4 && k < ack_id.size(); k++) begin
            chk("t38_order", ack_id[k], k % 2);
            chk("t38_cycle", ack_c[k], 7 + 8 * k);
        end
        repeat (2) @(negedge clk);

        // Reset during beat 3 aborts the frame; a re-request then completes.
        req0 = 1'b1; we0 = 1'b1; addr0 = 16'h5A5A; data0 = $urandom;
        nb = 0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (send) nb++;
            if (nb == 4) break;
        end
        chk("t40_reached_beat3", nb, 4);
        rxc0 = rx_cnt;
        reset = 1'b1;
        @(negedge clk);
        chk("t40_send", send, 1'b0);
        chk("t40_busy", busy, 1'b0);
        chk("t40_acks", {ack0, ack1}, 2'b00);
        reset = 1'b0;
        ackc = 0;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (ack0) begin ackc = c; break; end
        end
        req0 = 1'b0;
        chk("t40_reack_cycle", ackc, 7);
        repeat (2) @(negedge clk);
        chk("t40_rx_frames", rx_cnt - rxc0, 1);
        chk("t40_rx_addr", rx_addr, 16'h5A5A);

        // 20-bit data: 5 beats, padded top nibble, ack one cycle after last beat.
        req0 = 1'b1; we0 = 1'b1; addr0 = 16'hABCD; data0 = 32'h000FBEEF;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            if (c <= 5) begin
                chk("t42_send", send_20, 1'b1);
                chk("t42_beat", bus_20, lit42[c-1]);
                chk("t42_no_ack", ack0_20, 1'b0);
            end else begin
                chk("t42_send_low", send_20, 1'b0);
                chk("t42_ack0", ack0_20, 1'b1);
                chk("t42_bus_zero", bus_20, 8'h00);
            end
            if (c == 5) chk("t42_pad", bus_20[7:4], 4'h0);
        end
        req0 = 1'b0;
        repeat (4) @(negedge clk);

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            reset = ($urandom_range(0, 249) == 0);
            req0  = ($urandom_range(0, 99) < 55);
            req1  = ($urandom_range(0, 99) < 55);
            we0   = $urandom_range(0, 1);
            we1   = $urandom_range(0, 1);
            addr0 = 16'($urandom);
            addr1 = 16'($urandom);
            data0 = $urandom;
            data1 = $urandom;
            @(negedge clk);
        end
        reset = 1'b0; req0 = 1'b0; req1 = 1'b0;
        repeat (12) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
